// File: rtl/multi_byte_instruction_register.sv
// multi_byte_instruction_register: assembles variable-length SAP instructions from the W bus and returns the operand to the bus
module multi_byte_instruction_register #(
  parameter int DATA_WIDTH = 8,
  parameter int OPCODE_WIDTH = 4,
  parameter int EXT_BYTES = 1,
  parameter logic [2**OPCODE_WIDTH-1:0] LONG_OPCODE_MASK = 16'h0F00,
  parameter int SEL_WIDTH = 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             load_n_i,
  input  logic                             enable_n_i,
  input  logic                             flush_i,
  input  logic [SEL_WIDTH-1:0]             bus_byte_sel_i,
  inout  tri   [DATA_WIDTH-1:0]            w_bus_io,
  output logic [OPCODE_WIDTH-1:0]          opcode_o,
  output logic [EXT_BYTES*DATA_WIDTH-1:0]  operand_o,
  output logic                             instr_valid_o,
  output logic                             fetch_busy_o
);
  localparam int CW = EXT_BYTES > 1 ? $clog2(EXT_BYTES) : 1;
  localparam int OW = EXT_BYTES * DATA_WIDTH;
  localparam int AW = DATA_WIDTH - OPCODE_WIDTH;
  typedef enum logic [1:0] {EMPTY, GATHER, VALID} state_t;
  state_t state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [OW-1:0] operand_q, operand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OPCODE_WIDTH-1:0] op_in;
  logic [DATA_WIDTH-1:0] sel_byte;
  logic drive;
  assign op_in = w_bus_io[DATA_WIDTH-1 -: OPCODE_WIDTH];
  // State register; reset discards any partial instruction
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= EMPTY;
      opcode_q  <= '0;
      operand_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      cnt_q     <= cnt_d;
    end
  end
  // Next state: flush aborts, otherwise a load either gathers an operand byte or starts a new instruction
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    cnt_d     = cnt_q;
    if (flush_i) begin
      state_d   = EMPTY;
      operand_d = '0;
      cnt_d     = '0;
    end else if (!load_n_i) begin
      if (state_q == GATHER) begin
        operand_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = w_bus_io;
        cnt_d   = cnt_q == CW'(EXT_BYTES - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(EXT_BYTES - 1) ? VALID : GATHER;
      end else begin
        opcode_d  = op_in;
        operand_d = '0;
        cnt_d     = '0;
        state_d   = LONG_OPCODE_MASK[op_in] ? GATHER : VALID;
        if (!LONG_OPCODE_MASK[op_in]) operand_d[AW-1:0] = w_bus_io[AW-1:0];
      end
    end
  end
  // Shifting past the operand yields zeros, so out-of-range selects drive 0
  assign sel_byte = DATA_WIDTH'(operand_q >> (bus_byte_sel_i * DATA_WIDTH));
  assign drive = !enable_n_i && load_n_i && state_q == VALID;
  assign w_bus_io = drive ? sel_byte : 'z;
  assign opcode_o = opcode_q;
  assign operand_o = operand_q;
  assign instr_valid_o = state_q == VALID;
  assign fetch_busy_o = state_q == GATHER;
endmodule

// File: tb/tb_multi_byte_instruction_register.sv
// tb_multi_byte_instruction_register: model-checked bench for one- and two-extension-byte instruction registers
module tb_multi_byte_instruction_register;
  logic clk = 0, reset = 1, load_n = 1, enable_n = 1, flush = 0, sel = 0;
  logic [7:0] din = 0;
  tri1 [7:0] bus1, bus2;
  logic [3:0] op1, op2;
  logic [7:0] opnd1;
  logic [15:0] opnd2;
  logic v1, v2, b1, b2;
  int n_vec = 0, n_bad = 0;
  bit armed = 0;
  typedef struct packed {logic [3:0] op; logic [15:0] opnd; logic [7:0] got; logic busy; logic valid;} mdl_t;
  mdl_t m1 = '0, m2 = '0;
  always #5 clk = ~clk;
  assign bus1 = load_n ? 8'hzz : din;
  assign bus2 = load_n ? 8'hzz : din;
  multi_byte_instruction_register #(.EXT_BYTES(1), .SEL_WIDTH(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .load_n_i(load_n), .enable_n_i(enable_n), .flush_i(flush),
    .bus_byte_sel_i(sel), .w_bus_io(bus1), .opcode_o(op1), .operand_o(opnd1),
    .instr_valid_o(v1), .fetch_busy_o(b1));
  multi_byte_instruction_register #(.EXT_BYTES(2), .SEL_WIDTH(1)) dut2 (
    .clk_i(clk), .reset_i(reset), .load_n_i(load_n), .enable_n_i(enable_n), .flush_i(flush),
    .bus_byte_sel_i(sel), .w_bus_io(bus2), .opcode_o(op2), .operand_o(opnd2),
    .instr_valid_o(v2), .fetch_busy_o(b2));
  function automatic mdl_t step_mdl(mdl_t m, int ext);
    mdl_t n = m;
    if (reset) n = '0;
    else if (flush) begin
      n.busy = 0; n.valid = 0; n.opnd = 0; n.got = 0;
    end else if (!load_n) begin
      if (m.busy) begin
        n.opnd = m.opnd | (16'(din) << (8 * m.got));
        n.got = m.got + 1;
        if (int'(n.got) == ext) begin
          n.busy = 0; n.valid = 1; n.got = 0;
        end
      end else begin
        n.op = din[7:4];
        n.got = 0;
        n.busy = din[7:4] inside {[8:11]};
        n.valid = !n.busy;
        n.opnd = n.busy ? 16'h0 : {12'h0, din[3:0]};
      end
    end
    return n;
  endfunction
  function automatic logic [7:0] exp_bus(mdl_t m, int ext);
    if (!load_n) return din;
    if (!enable_n && m.valid) return int'(sel) < ext ? m.opnd[8*sel +: 8] : 8'h00;
    return 8'hFF;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drv(logic r, logic f, logic ld, logic en, logic s, logic [7:0] d);
    reset = r; flush = f; load_n = ld; enable_n = en; sel = s; din = d;
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    m1 <= step_mdl(m1, 1);
    m2 <= step_mdl(m2, 2);
  end
  always @(negedge clk) if (armed) begin
    chk("op1", op1, m1.op);
    chk("opnd1", opnd1, m1.opnd[7:0]);
    chk("valid1", v1, m1.valid);
    chk("busy1", b1, m1.busy);
    chk("bus1", bus1, exp_bus(m1, 1));
    chk("op2", op2, m2.op);
    chk("opnd2", opnd2, m2.opnd);
    chk("valid2", v2, m2.valid);
    chk("busy2", b2, m2.busy);
    chk("bus2", bus2, exp_bus(m2, 2));
  end
  initial begin
    tick();
    drv(1, 0, 1, 1, 0, 0); tick(); tick();
    armed = 1;
    chk("rst_op", op1, 0); chk("rst_valid", v1, 0); chk("rst_busy", b1, 0);
    chk("rst_opnd2", opnd2, 0); chk("rst_bus", bus1, 8'hFF);
    drv(0, 0, 0, 1, 0, 8'h1B); tick();
    chk("short_op", op1, 1); chk("short_opnd", opnd1, 8'h0B); chk("short_valid", v1, 1);
    drv(0, 0, 1, 0, 0, 0); #1 chk("short_bus", bus1, 8'h0B);
    sel = 1; #1 chk("sel_oob1", bus1, 8'h00); chk("sel_hi2", bus2, 8'h00);
    tick();
    drv(0, 0, 0, 0, 0, 8'h93); #1 chk("both_low_bus", bus1, 8'h93);
    tick();
    chk("long_busy", b1, 1); chk("long_valid", v1, 0); chk("long_op", op1, 9);
    drv(0, 0, 1, 0, 0, 0); #1 chk("gather_bus1", bus1, 8'hFF); chk("gather_bus2", bus2, 8'hFF);
    tick();
    drv(0, 0, 0, 1, 0, 8'h5C); tick();
    chk("ext_opnd", opnd1, 8'h5C); chk("ext_valid", v1, 1); chk("part_busy2", b2, 1);
    drv(0, 1, 1, 1, 0, 0); tick();
    chk("fl_valid", v1, 0); chk("fl_opnd", opnd1, 0); chk("fl_op", op1, 9);
    chk("fl_busy2", b2, 0); chk("fl_opnd2", opnd2, 0); chk("fl_op2", op2, 9);
    drv(0, 0, 0, 1, 0, 8'h83); tick();
    chk("two_busy_a", b2, 1); chk("two_op", op2, 8);
    drv(0, 0, 0, 1, 0, 8'h34); tick();
    chk("two_busy_b", b2, 1); chk("one_opnd34", opnd1, 8'h34);
    drv(0, 0, 0, 1, 0, 8'h12); tick();
    chk("two_opnd", opnd2, 16'h1234); chk("two_valid", v2, 1);
    chk("one_op1", op1, 1); chk("one_opnd02", opnd1, 8'h02);
    drv(0, 0, 1, 0, 0, 0); #1 chk("two_bus_lo", bus2, 8'h34);
    sel = 1; #1 chk("two_bus_hi", bus2, 8'h12);
    tick();
    drv(0, 0, 0, 1, 0, 8'h93); tick();
    drv(1, 0, 1, 1, 0, 0); tick();
    chk("mid_rst_op", op1, 0); chk("mid_rst_busy", b1, 0); chk("mid_rst_valid", v1, 0);
    chk("mid_rst_op2", op2, 0); chk("mid_rst_busy2", b2, 0);
    drv(0, 0, 0, 1, 0, 8'h1B); tick();
    chk("b2b_v1", v1, 1); chk("b2b_op1", op1, 1);
    din = 8'h2C; tick();
    chk("b2b_v2", v1, 1); chk("b2b_op2", op1, 2); chk("b2b_opnd2", opnd1, 8'h0C);
    din = 8'h9D; tick();
    chk("b2b_op3", op1, 9); chk("b2b_busy3", b1, 1); chk("b2b_v3", v1, 0);
    drv(0, 0, 1, 1, 0, 0); tick(); tick(); tick();
    chk("hold_busy", b1, 1);
    drv(0, 0, 0, 1, 0, 8'hAA); tick();
    chk("hold_opnd", opnd1, 8'hAA); chk("hold_valid", v1, 1); chk("hold_busy2", b2, 1);
    drv(0, 1, 0, 1, 0, 8'h1B); tick();
    chk("fl_prio_valid", v1, 0); chk("fl_prio_op", op1, 9);
    drv(0, 0, 1, 1, 0, 0); tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
